// File: rtl/pc_fetch_sequencer.sv
// IF-stage PC owner and imem requester with a one-deep decode buffer.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module pc_fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int TGT_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic jump_valid,
  input  logic [TGT_W-1:0] jump_target,
  output logic imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [INSTR_W-1:0] out_q, out_d;
  logic discard_q, discard_d;
  logic [ADDR_W-1:0] tgt;
  logic fire;
  logic flush;

  assign tgt = {{(ADDR_W-TGT_W){1'b0}}, jump_target};

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    ipc_d = ipc_q;
    out_d = out_q;
    discard_d = discard_q;
    fire = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (jump_valid) pc_d = tgt;
        if (en) state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (jump_valid) begin
            pc_d = tgt;
            discard_d = 1'b0;
            flush = !discard_q;
          end else if (discard_q) begin
            pc_d = pend_q;
            discard_d = 1'b0;
          end else begin
            out_d = imem_rdata;
            ipc_d = pc_q;
            state_d = HOLD;
          end
        end else if (jump_valid) begin
          // pc must not move under an outstanding request
          discard_d = 1'b1;
          pend_d = tgt;
          flush = !discard_q;
        end
      end
      HOLD: begin
        if (jump_valid || instr_ready) begin
          state_d = en ? REQ : IDLE;
          pc_d = jump_valid ? tgt : pc_q + ADDR_W'(1);
          fire = instr_ready;
          flush = jump_valid && !instr_ready;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      pend_q <= '0;
      ipc_q <= '0;
      out_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      ipc_q <= ipc_d;
      out_q <= out_d;
      discard_q <= discard_d;
    end
  end

  assign imem_req = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instr_out = out_q;
  assign instr_pc = ipc_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (fire && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = fire ^ flush;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus random traffic
// against a transaction-level fetch model.
module tb_pc_fetch_sequencer;

  logic clk = 1'b0;
  logic rst, en, jump_valid, imem_ack, instr_ready;
  logic [7:0] jump_target;
  logic [31:0] imem_rdata;
  logic imem_req, instr_valid;
  logic [11:0] imem_addr, instr_pc, pc;
  logic [31:0] instr_out;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count, flush_count;
`endif

  int vectors = 0;
  int errors = 0;

  // model: request in flight, word buffered, response to drop
  bit m_busy, m_held, m_drop;
  logic [11:0] m_pc, m_pend, m_ipc;
  logic [31:0] m_instr;

  pc_fetch_sequencer dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .jump_valid(jump_valid),
    .jump_target(jump_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit r, bit e, bit jv, logic [7:0] jt,
                                     bit ak, logic [31:0] rd, bit rdy);
    logic [11:0] t;
    t = {4'b0, jt};
    if (r) begin
      m_busy = 0; m_held = 0; m_drop = 0;
      m_pc = 12'h000; m_ipc = 12'h000; m_instr = 32'h0;
    end else if (m_busy) begin
      if (ak) begin
        if (jv) begin
          m_pc = t; m_drop = 0;
        end else if (m_drop) begin
          m_pc = m_pend; m_drop = 0;
        end else begin
          m_instr = rd; m_ipc = m_pc; m_busy = 0; m_held = 1;
        end
      end else if (jv) begin
        m_drop = 1; m_pend = t;
      end
    end else if (m_held) begin
      if (rdy || jv) begin
        m_held = 0;
        m_busy = e;
        m_pc = jv ? t : m_pc + 12'd1;
      end
    end else begin
      if (jv) m_pc = t;
      m_busy = e;
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit jv,
                     input logic [7:0] jt, input bit ak,
                     input logic [31:0] rd, input bit rdy);
    rst = r; en = e; jump_valid = jv; jump_target = jt;
    imem_ack = ak; imem_rdata = rd; instr_ready = rdy;
    @(posedge clk);
    model_step(r, e, jv, jt, ak, rd, rdy);
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_busy));
    chk("instr_valid", 32'(instr_valid), 32'(m_held));
    chk("pc", 32'(pc), 32'(m_pc));
    if (m_busy) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    if (m_held) begin
      chk("instr_out", instr_out, m_instr);
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
  endtask

  initial begin
    cyc(1, 0, 0, 8'h00, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_iout", instr_out, 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h000);

    // back-to-back fetch with zero-latency ack
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    chk("seq_addr0", 32'(imem_addr), 32'h000);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 8'h00, 1, 32'h100 + 32'(k), 1);
      chk("seq_ipc", 32'(instr_pc), 32'(k));
      chk("seq_iout", instr_out, 32'h100 + 32'(k));
      cyc(0, 1, 0, 8'h00, 0, 0, 1);
      chk("seq_addr", 32'(imem_addr), 32'(k + 1));
    end

    // jump in HOLD, decode not ready
    cyc(0, 1, 0, 8'h00, 1, 32'h333, 0);
    cyc(0, 1, 1, 8'hA5, 0, 0, 0);
    chk("hold_jmp_valid", 32'(instr_valid), 32'd0);
    chk("hold_jmp_addr", 32'(imem_addr), 32'h0A5);

    // jump in REQ, ack three cycles later gets dropped
    cyc(0, 1, 1, 8'h3C, 0, 0, 0);
    chk("req_jmp_hold", 32'(imem_addr), 32'h0A5);
    cyc(0, 1, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 8'h00, 0, 0, 0);
    chk("req_jmp_hold2", 32'(imem_addr), 32'h0A5);
    cyc(0, 1, 0, 8'h00, 1, 32'hDEADBEEF, 0);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_addr", 32'(imem_addr), 32'h03C);
    cyc(0, 1, 0, 8'h00, 1, 32'h1234, 0);
    chk("redir_ipc", 32'(instr_pc), 32'h03C);

    // ready and jump together
    cyc(0, 1, 1, 8'h10, 0, 0, 1);
    chk("rdy_jmp_addr", 32'(imem_addr), 32'h010);

    // en low while request outstanding
    cyc(0, 0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 1, 32'h55, 0);
    chk("en0_valid", 32'(instr_valid), 32'd1);
    cyc(0, 0, 0, 8'h00, 0, 0, 1);
    chk("en0_idle_req", 32'(imem_req), 32'd0);

    // reset during REQ, late ack ignored
    cyc(0, 1, 0, 8'h00, 0, 0, 0);
    cyc(1, 1, 0, 8'h00, 0, 0, 0);
    chk("rst_req_pc", 32'(pc), 32'h000);
    cyc(0, 0, 0, 8'h00, 1, 32'hBAD, 1);
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_req", 32'(imem_req), 32'd0);

    // walk pc up to 0xFFF and wrap
    cyc(0, 1, 1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 4000 && m_pc != 12'hFFF; i++) begin
      cyc(0, 1, 0, 8'h00, 1, 32'(i), 1);
      cyc(0, 1, 0, 8'h00, 0, 0, 1);
    end
    cyc(0, 1, 0, 8'h00, 1, 32'hF00D, 0);
    chk("wrap_ipc", 32'(instr_pc), 32'hFFF);
    cyc(0, 1, 0, 8'h00, 0, 0, 1);
    chk("wrap_addr", 32'(imem_addr), 32'h000);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, e, jv, ak, rdy;
      r = ($urandom_range(199) == 0);
      e = ($urandom_range(5) != 0);
      jv = ($urandom_range(9) == 0);
      ak = m_busy && ($urandom_range(2) == 0);
      rdy = ($urandom_range(1) == 0);
      cyc(r, e, jv, 8'($urandom), ak, $urandom, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
